// File: rtl/feature_weight_bank.sv
`timescale 1ns/1ps
// feature_weight_bank
// Double-buffered store of signed convolution weights for NUM_FEATURES filters,
// each NUM_CHANNELS x KERNEL_SIZE x KERNEL_SIZE. Weights are streamed into the
// shadow bank one feature at a time. The active bank drives every PE in
// parallel through weights_out. A swap exchanges the two banks between layers.
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst           asynchronous active-low reset
//   load_start    one-cycle request to load one feature into the shadow bank
//   load_feature  feature index, sampled with load_start
//   w_valid       weight stream valid
//   w_data        signed weight value
//   w_ready       weight stream ready (high only while loading)
//   swap          exchange active and shadow banks (honoured only when idle)
//   busy          FSM is not idle
//   load_done     one-cycle pulse when a feature load completes
//   load_err      one-cycle pulse after load_start with an out-of-range index
//   shadow_valid  per-feature flag: fully loaded into shadow since last swap
//   active_bank   index of the bank currently driving weights_out
//   weights_out   active-bank weights; element (f,e) at [(f*N_ELEM+e)*W +: W],
//                 with e = c*K*K + row*K + col
module feature_weight_bank #(
  parameter  int KERNEL_SIZE  = 3,
  parameter  int NUM_FEATURES = 10,
  parameter  int NUM_CHANNELS = 1,
  parameter  int WEIGHT_WIDTH = 2,
  localparam int N_ELEM       = NUM_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int FW           = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int CW           = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load_start,
  input  logic [FW-1:0]                               load_feature,
  input  logic                                        w_valid,
  input  logic signed [WEIGHT_WIDTH-1:0]              w_data,
  output logic                                        w_ready,
  input  logic                                        swap,
  output logic                                        busy,
  output logic                                        load_done,
  output logic                                        load_err,
  output logic [NUM_FEATURES-1:0]                     shadow_valid,
  output logic                                        active_bank,
  output logic [NUM_FEATURES*N_ELEM*WEIGHT_WIDTH-1:0] weights_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [CW-1:0]                 r_count;
  logic [FW-1:0]                 r_feature;
  logic                          r_active;
  logic [NUM_FEATURES-1:0]       r_shadow_valid;
  logic                          r_load_err;
  logic signed [WEIGHT_WIDTH-1:0] r_bank [2][NUM_FEATURES][N_ELEM];

  logic w_feature_ok;
  logic w_swap_go;
  logic w_start_go;
  logic w_start_bad;
  logic w_beat;
  logic w_last_beat;

  assign w_feature_ok = int'(load_feature) < NUM_FEATURES;
  // Swap wins over a simultaneous load_start; the dropped start raises no error.
  assign w_swap_go    = (r_state == S_IDLE) && swap;
  assign w_start_go   = (r_state == S_IDLE) && !swap && load_start && w_feature_ok;
  assign w_start_bad  = (r_state == S_IDLE) && !swap && load_start && !w_feature_ok;
  // w_ready is high for the whole LOAD state, so a beat is just w_valid there.
  assign w_beat       = (r_state == S_LOAD) && w_valid;
  assign w_last_beat  = w_beat && (r_count == CW'(N_ELEM - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_go)  w_next_state = S_LOAD;
      S_LOAD:  if (w_last_beat) w_next_state = S_DONE;
      S_DONE:                   w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready   = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count        <= '0;
      r_feature      <= '0;
      r_active       <= 1'b0;
      r_shadow_valid <= '0;
      r_load_err     <= 1'b0;
    end else begin
      r_load_err <= w_start_bad;

      if (w_start_go) begin
        r_feature <= load_feature;
        r_count   <= '0;
      end else if (w_beat) begin
        r_count <= w_last_beat ? '0 : r_count + 1'b1;
      end

      // A swap hands the freshly loaded set to compute; nothing in the new
      // shadow bank counts as loaded yet, even though its old contents remain.
      if (w_swap_go) begin
        r_active       <= ~r_active;
        r_shadow_valid <= '0;
      end else if (r_state == S_DONE) begin
        r_shadow_valid[r_feature] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Weight storage: only the shadow bank (~r_active) is ever written.
  // ---------------------------------------------------------------------------
  // NOTE: the banks are register arrays, not RAM macros, and reset must wipe
  // any partially loaded filter, so they take the asynchronous reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int f = 0; f < NUM_FEATURES; f++)
          for (int e = 0; e < N_ELEM; e++)
            r_bank[b][f][e] <= '0;
    end else if (w_beat) begin
      r_bank[~r_active][r_feature][r_count] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Flat, combinational view of the active bank
  // ---------------------------------------------------------------------------
  always_comb begin
    weights_out = '0;
    for (int f = 0; f < NUM_FEATURES; f++)
      for (int e = 0; e < N_ELEM; e++)
        weights_out[(f*N_ELEM + e)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_bank[r_active][f][e];
  end

  assign shadow_valid = r_shadow_valid;
  assign active_bank  = r_active;
  assign load_err     = r_load_err;

endmodule

// File: tb/tb_feature_weight_bank.sv
`timescale 1ns/1ps
// Self-checking bench for feature_weight_bank. A transaction-level model keeps
// both banks as plain arrays and is updated once per completed load or swap.
// A second instance with NUM_CHANNELS=2, WEIGHT_WIDTH=4 covers the wider
// channel-major layout.
module tb_feature_weight_bank;

  localparam int K   = 3;
  localparam int F   = 10;
  localparam int C   = 1;
  localparam int W   = 2;
  localparam int N   = C*K*K;
  localparam int OW  = F*N*W;
  localparam int C2  = 2;
  localparam int W2  = 4;
  localparam int N2  = C2*K*K;
  localparam int OW2 = F*N2*W2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1 (default parameters)
  logic          ls, wv, sw;
  logic [3:0]    lf;
  logic [W-1:0]  wd;
  logic          wr, busy, ld, le, ab;
  logic [F-1:0]  sv;
  logic [OW-1:0] wout;

  // Instance 2 (two channels, 4-bit weights)
  logic           ls2, wv2, sw2;
  logic [3:0]     lf2;
  logic [W2-1:0]  wd2;
  logic           wr2, busy2, ld2, le2, ab2;
  logic [F-1:0]   sv2;
  logic [OW2-1:0] wout2;

  feature_weight_bank #(
    .KERNEL_SIZE (K), .NUM_FEATURES(F), .NUM_CHANNELS(C), .WEIGHT_WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .load_start(ls), .load_feature(lf),
    .w_valid(wv), .w_data(wd), .w_ready(wr), .swap(sw), .busy(busy),
    .load_done(ld), .load_err(le), .shadow_valid(sv), .active_bank(ab),
    .weights_out(wout)
  );

  feature_weight_bank #(
    .KERNEL_SIZE (K), .NUM_FEATURES(F), .NUM_CHANNELS(C2), .WEIGHT_WIDTH(W2)
  ) dut2 (
    .clk(clk), .rst(rst), .load_start(ls2), .load_feature(lf2),
    .w_valid(wv2), .w_data(wd2), .w_ready(wr2), .swap(sw2), .busy(busy2),
    .load_done(ld2), .load_err(le2), .shadow_valid(sv2), .active_bank(ab2),
    .weights_out(wout2)
  );

  // Reference model
  logic [W-1:0] m_bank [2][F][N];
  logic         m_act;
  logic [F-1:0] m_valid;
  logic [W-1:0] cur_vals [N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int f = 0; f < F; f++)
        for (int e = 0; e < N; e++)
          m_bank[b][f][e] = '0;
    m_act   = 1'b0;
    m_valid = '0;
  endtask

  function automatic logic [OW-1:0] exp_wout();
    logic [OW-1:0] v;
    v = '0;
    for (int f = 0; f < F; f++)
      for (int e = 0; e < N; e++)
        v[(f*N + e)*W +: W] = m_bank[m_act][f][e];
    return v;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_wout"},  wout, exp_wout());
    check({tag, "_abank"}, ab,   m_act);
    check({tag, "_svalid"}, sv,  m_valid);
  endtask

  // gap_mode: 0 = w_valid held high, 1 = toggles every cycle, 2 = random gaps.
  // swap_mid pulses swap during an idle gap inside the load.
  task automatic do_load(input int f, input int gap_mode, input bit swap_mid);
    @(negedge clk); ls = 1'b1; lf = 4'(f);
    @(negedge clk); ls = 1'b0;
    check("load_busy",  busy, 1'b1);
    check("load_ready", wr,   1'b1);
    for (int i = 0; i < N; i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1) ||
          (swap_mid && i == 4)) begin
        wv = 1'b0;
        if (swap_mid && i == 4) sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
      end
      wv = 1'b1; wd = cur_vals[i];
      @(negedge clk);
      if (i < N-1) check("no_early_done", ld, 1'b0);
    end
    wv = 1'b0;
    check("done_pulse", ld, 1'b1);
    check("done_ready", wr, 1'b0);
    for (int e = 0; e < N; e++) m_bank[m_act ^ 1'b1][f][e] = cur_vals[e];
    m_valid[f] = 1'b1;
    @(negedge clk);
    check("done_cleared", ld,   1'b0);
    check("idle_busy",    busy, 1'b0);
    check_state("after_load");
  endtask

  task automatic do_swap();
    @(negedge clk); sw = 1'b1;
    @(negedge clk); sw = 1'b0;
    m_act   = m_act ^ 1'b1;
    m_valid = '0;
    check_state("after_swap");
  endtask

  task automatic do_bad_load(input int f);
    @(negedge clk); ls = 1'b1; lf = 4'(f);
    @(negedge clk); ls = 1'b0;
    check("err_pulse", le,   1'b1);
    check("err_busy",  busy, 1'b0);
    @(negedge clk);
    check("err_cleared", le, 1'b0);
    check_state("after_err");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [OW2-1:0] e2;
    int r;

    rst = 1'b0;
    ls = 0; lf = 0; wv = 0; wd = 0; sw = 0;
    ls2 = 0; lf2 = 0; wv2 = 0; wd2 = 0; sw2 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check_state("reset");
    check("reset_ready", wr,   1'b0);
    check("reset_busy",  busy, 1'b0);
    check("reset_done",  ld,   1'b0);
    check("reset_err",   le,   1'b0);

    // Directed load of feature 3: +1,-1,0,-2,+1,+1,-1,0,-2
    cur_vals = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10};
    do_load(3, 0, 1'b0);
    check("svalid_f3", sv, 10'h008);
    check("wout_still_zero", wout, '0);

    do_swap();
    check("abank_after_swap", ab, 1'b1);

    // Out-of-range feature index
    do_bad_load(12);

    // Same load with w_valid toggling, swap pulse mid-load must be ignored
    do_load(3, 1, 1'b1);
    check("svalid_after_toggle", sv, 10'h008);

    // Swap and load_start together: swap wins, start is dropped silently
    @(negedge clk); sw = 1'b1; ls = 1'b1; lf = 4'd2;
    @(negedge clk); sw = 1'b0; ls = 1'b0;
    check("swap_prio_busy", busy, 1'b0);
    check("swap_prio_err",  le,   1'b0);
    m_act = m_act ^ 1'b1; m_valid = '0;
    check_state("swap_prio");

    // Reset after 4 of 9 beats
    for (int i = 0; i < N; i++) cur_vals[i] = W'($urandom_range(0, 3));
    @(negedge clk); ls = 1'b1; lf = 4'd5;
    @(negedge clk); ls = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wv = 1'b1; wd = cur_vals[i];
      @(negedge clk);
    end
    wv = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    check("mid_reset_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < N; i++) cur_vals[i] = W'($urandom_range(0, 3));
    do_load(0, 0, 1'b0);
    do_swap();

    // Randomised mix of loads, swaps, bad indices and idle cycles
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        for (int i = 0; i < N; i++) cur_vals[i] = W'($urandom_range(0, 3));
        do_load($urandom_range(0, F-1), 2, 1'($urandom_range(0, 1)));
      end else if (r <= 7) begin
        do_swap();
      end else if (r == 8) begin
        do_bad_load($urandom_range(F, 15));
      end else begin
        @(negedge clk);
        check_state("idle");
      end
    end

    // Wide instance: feature 1, 18 beats of i mod 16, channel-major order
    @(negedge clk); ls2 = 1'b1; lf2 = 4'd1;
    @(negedge clk); ls2 = 1'b0;
    for (int i = 0; i < N2; i++) begin
      wv2 = 1'b1; wd2 = W2'(i % 16);
      @(negedge clk);
    end
    wv2 = 1'b0;
    check("w2_done_pulse", ld2, 1'b1);
    @(negedge clk);
    check("w2_svalid", sv2, 10'h002);
    check("w2_wout_pre_swap", wout2, '0);
    @(negedge clk); sw2 = 1'b1;
    @(negedge clk); sw2 = 1'b0;
    e2 = '0;
    for (int e = 0; e < N2; e++) e2[(1*N2 + e)*W2 +: W2] = W2'(e % 16);
    check("w2_abank", ab2, 1'b1);
    check("w2_wout",  wout2, e2);
    check("w2_svalid_cleared", sv2, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/feature_weight_bank.md
Name: feature_weight_bank

Overview:
- Double-buffered, parametrised successor to the single-bank feature weight store.
- Holds signed convolution weights for NUM_FEATURES filters, each NUM_CHANNELS x KERNEL_SIZE x KERNEL_SIZE.
- Weights arrive through a valid/ready stream into a shadow bank, one feature at a time, while the active bank drives all PEs in parallel.
- A swap request atomically exchanges the banks between layers, so compute never sees a partially loaded filter set.

Parameters:
- KERNEL_SIZE, 3, kernel edge length K.
- NUM_FEATURES, 10, number of filters F.
- NUM_CHANNELS, 1, input channels per filter C.
- WEIGHT_WIDTH, 2, signed bits per weight W.
- Derived: N_ELEM = C*K*K; FW = max(1, $clog2(F)); CW = max(1, $clog2(N_ELEM)).

Ports:
- clk  in  1  main chip clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin loading one feature into the shadow bank.
- load_feature  in  FW  feature index, sampled with load_start.
- w_valid  in  1  weight stream valid.
- w_data  in  W  signed weight value.
- w_ready  out  1  weight stream ready.
- swap  in  1  request to exchange the active and shadow banks.
- busy  out  1  high when the FSM is not IDLE.
- load_done  out  1  one-cycle pulse when a feature load completes.
- load_err  out  1  one-cycle pulse when load_start carries an invalid index.
- shadow_valid  out  F  per-feature flag: fully loaded into the shadow bank since the last swap.
- active_bank  out  1  index of the bank currently driving weights_out.
- weights_out  out  F*N_ELEM*W  active-bank weights, flat packed. Element (f,e) occupies bits [(f*N_ELEM+e)*W +: W].

Behaviour:
- Storage: two banks, bank[2][F][N_ELEM] of signed W-bit registers.
- Element order: e = c*K*K + row*K + col. Channel-major, then kernel row-major.
- weights_out is combinational from bank[active_bank].
- Reset (rst=0, async):
  - both banks cleared to 0;
  - active_bank=0, FSM=IDLE, element counter=0, latched feature=0;
  - shadow_valid=0, w_ready=0, busy=0, load_done=0, load_err=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - swap=1 → active_bank toggles at the next edge and shadow_valid clears to 0. Stay IDLE.
  - Swap has priority: a load_start in the same cycle is dropped (no load_err).
  - load_start=1 with load_feature<F → latch the feature, counter=0, go to LOAD.
  - load_start=1 with load_feature>=F → load_err=1 for the next cycle, stay IDLE, no write.
- LOAD:
  - w_ready=1, busy=1.
  - Each cycle with w_valid&&w_ready writes w_data to shadow[feature][counter] and increments counter.
  - A beat with counter==N_ELEM-1 moves to DONE. Exactly N_ELEM beats are accepted.
  - w_valid low stalls the load indefinitely with no timeout.
  - load_start and swap are ignored in LOAD.
- DONE (one cycle):
  - w_ready=0, busy=1, load_done=1;
  - shadow_valid[feature] set at the exit edge;
  - next state IDLE. load_start and swap are ignored.
- Reloading an already valid feature overwrites it. Its shadow_valid bit stays 1.
- Swap does not clear the new shadow bank: it retains the prior active contents, so partial reloads are legal.
- The active bank is never written.
- Latency:
  - the first weight of a load can be accepted the cycle after load_start;
  - the minimum load is N_ELEM+2 cycles from load_start to return to IDLE;
  - new weights appear on weights_out the cycle after the swap edge.
- Reset asserted mid-LOAD aborts the load and clears all state. No partial data survives.

Test Plan:
- Reset with no writes → weights_out all 0, active_bank=0, shadow_valid=0, w_ready=0, busy=0.
- load_start with feature 3, then 9 beats of w_data=+1,-1,0,-2,+1,+1,-1,0,-2 with w_valid held high:
  - load_done pulses exactly one cycle after the 9th beat;
  - shadow_valid=0x008;
  - weights_out still 0.
- Then swap=1 →
  - active_bank=1;
  - feature 3 slice on weights_out reads +1,-1,0,-2,+1,+1,-1,0,-2;
  - every other feature slice reads 0;
  - shadow_valid=0.
- load_start with feature 12 → load_err pulses 1 cycle, FSM stays IDLE, no bank changes.
- Same load as scenario 2, but w_valid toggles 1/0 every cycle →
  - only valid beats are written;
  - load_done pulses after the 9th valid beat;
  - a swap pulse mid-load is ignored: active_bank does not change and shadow_valid is not cleared.
- Assert rst after 4 of 9 beats → both banks 0, FSM IDLE, shadow_valid=0; a following full load of feature 0 completes normally.
- Run with NUM_CHANNELS=2, WEIGHT_WIDTH=4, load feature 1 with 18 beats of values 0..17 mod 16 as signed → after swap, feature 1 slice matches in channel-major order.
